mult_arbiter: RTL and testbench

Shares one 8x8 sequential multiplier (controller plus datapath) between two requesters. Selects a requester by 2-way round-robin and latches its operands. Pulses start to the multiplier controller, waits for its done, then returns the 16-bit product with a one-cycle ack to the granted requester. A watchdog aborts the transaction with an error if done never arrives.

---
 rtl/mult_arbiter_pkg.sv | 15 +
 rtl/mult_arbiter_rr_pick2.sv | 22 ++
 rtl/mult_arbiter.sv | 139 +++++++++++++
 tb/tb_mult_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mult_arbiter_pkg.sv
// Shared constants for the two-requester multiplier arbiter.
package mult_arbiter_pkg;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_LAUNCH = 2'b01;
  localparam logic [1:0] ST_WAIT   = 2'b10;
  localparam logic [1:0] ST_RESP   = 2'b11;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_TIMEOUT = 16;

endpackage

// File: rtl/mult_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: on a tie the requester not served last wins.
module rr_pick2
  import mult_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = REQ0;
    unique case (req)
      2'b01:   gnt_id = REQ0;
      2'b10:   gnt_id = REQ1;
      2'b11:   gnt_id = ~last_grant;
      default: gnt_id = REQ0;
    endcase
  end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one sequential multiplier between two requesters with round-robin
// grant, start/done handshake and a watchdog that aborts a stuck transaction.
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset_a,
  input  logic [1:0]           req,
  input  logic [WIDTH-1:0]     a0,
  input  logic [WIDTH-1:0]     b0,
  input  logic [WIDTH-1:0]     a1,
  input  logic [WIDTH-1:0]     b1,
  output logic [1:0]           ack,
  output logic [2*WIDTH-1:0]   result,
  output logic                 err,
  output logic                 busy,
  output logic                 grant_id,
  output logic                 mult_start,
  output logic [WIDTH-1:0]     mult_a,
  output logic [WIDTH-1:0]     mult_b,
  input  logic                 mult_done,
  input  logic [2*WIDTH-1:0]   mult_product,
  output logic [1:0]           state_out
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [1:0]         state_q, state_d;
  logic [1:0]         ack_q, ack_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               err_q, err_d;
  logic               mult_start_q, mult_start_d;
  logic [WIDTH-1:0]   mult_a_q, mult_a_d;
  logic [WIDTH-1:0]   mult_b_q, mult_b_d;
  logic               grant_id_q, grant_id_d;
  logic               last_grant_q, last_grant_d;
  logic [TW-1:0]      timer_q, timer_d;

  logic gnt_valid;
  logic gnt_id;

  rr_pick2 u_pick (
    .req        (req),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  // ack and mult_start are registered on entry to RESP/LAUNCH so they are
  // high exactly while the FSM sits in that state.
  always_comb begin
    state_d      = state_q;
    ack_d        = '0;
    result_d     = result_q;
    err_d        = err_q;
    mult_start_d = 1'b0;
    mult_a_d     = mult_a_q;
    mult_b_d     = mult_b_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    timer_d      = timer_q;

    unique case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          state_d      = ST_LAUNCH;
          grant_id_d   = gnt_id;
          mult_start_d = 1'b1;
          mult_a_d     = (gnt_id == REQ1) ? a1 : a0;
          mult_b_d     = (gnt_id == REQ1) ? b1 : b0;
        end
      end
      ST_LAUNCH: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (timer_q != TW'(TIMEOUT)) timer_d = timer_q + 1'b1;
        // done takes priority over the watchdog in the same cycle
        if (mult_done) begin
          result_d          = mult_product;
          err_d             = 1'b0;
          ack_d[grant_id_q] = 1'b1;
          state_d           = ST_RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          result_d          = '0;
          err_d             = 1'b1;
          ack_d[grant_id_q] = 1'b1;
          state_d           = ST_RESP;
        end
      end
      ST_RESP: begin
        last_grant_d = grant_id_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_a) begin
      state_q      <= ST_IDLE;
      ack_q        <= '0;
      result_q     <= '0;
      err_q        <= 1'b0;
      mult_start_q <= 1'b0;
      mult_a_q     <= '0;
      mult_b_q     <= '0;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      ack_q        <= ack_d;
      result_q     <= result_d;
      err_q        <= err_d;
      mult_start_q <= mult_start_d;
      mult_a_q     <= mult_a_d;
      mult_b_q     <= mult_b_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      timer_q      <= timer_d;
    end
  end

  assign ack        = ack_q;
  assign result     = result_q;
  assign err        = err_q;
  assign busy       = (state_q != ST_IDLE);
  assign grant_id   = grant_id_q;
  assign mult_start = mult_start_q;
  assign mult_a     = mult_a_q;
  assign mult_b     = mult_b_q;
  assign state_out  = state_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter; the bench plays the multiplier controller.
module tb_mult_arbiter;

  logic        clk = 1'b0;
  logic        reset_a;
  logic [1:0]  req;
  logic [7:0]  a0, b0, a1, b1;
  logic [1:0]  ack;
  logic [15:0] result;
  logic        err, busy, grant_id, mult_start;
  logic [7:0]  mult_a, mult_b;
  logic        mult_done;
  logic [15:0] mult_product;
  logic [1:0]  state_out;

  int n_cmp = 0;
  int n_err = 0;

  mult_arbiter #(.WIDTH(8), .TIMEOUT(16)) dut (
    .clk          (clk),
    .reset_a      (reset_a),
    .req          (req),
    .a0           (a0),
    .b0           (b0),
    .a1           (a1),
    .b1           (b1),
    .ack          (ack),
    .result       (result),
    .err          (err),
    .busy         (busy),
    .grant_id     (grant_id),
    .mult_start   (mult_start),
    .mult_a       (mult_a),
    .mult_b       (mult_b),
    .mult_done    (mult_done),
    .mult_product (mult_product),
    .state_out    (state_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_a = 1'b1;
    tick();
    reset_a = 1'b0;
  endtask

  // One full transaction from IDLE: wait_n WAIT cycles without done, then
  // optionally done with prod; checks LAUNCH, WAIT, RESP and the return to IDLE.
  task automatic do_txn(input string tag, input logic [1:0] r, input int wait_n,
                        input logic give_done, input logic [15:0] prod,
                        input logic exp_id, input logic [7:0] exp_a, input logic [7:0] exp_b,
                        input logic [15:0] exp_res, input logic exp_err,
                        input logic [1:0] r_after);
    req = r;
    tick();
    chk({tag, ".launch_state"}, 32'(state_out), 32'h1);
    chk({tag, ".start"},        32'(mult_start), 32'h1);
    chk({tag, ".grant"},        32'(grant_id), 32'(exp_id));
    chk({tag, ".mult_a"},       32'(mult_a), 32'(exp_a));
    chk({tag, ".mult_b"},       32'(mult_b), 32'(exp_b));
    tick();
    chk({tag, ".wait_state"},   32'(state_out), 32'h2);
    chk({tag, ".start_low"},    32'(mult_start), 32'h0);
    for (int i = 0; i < wait_n; i++) begin
      tick();
      if (state_out !== 2'b10 || ack !== 2'b00) begin
        chk({tag, ".early_exit"}, {28'h0, ack, state_out}, 32'h2);
      end
    end
    chk({tag, ".held_a"}, 32'(mult_a), 32'(exp_a));
    if (give_done) begin
      mult_done    = 1'b1;
      mult_product = prod;
    end
    tick();
    mult_done    = 1'b0;
    mult_product = 16'h0;
    chk({tag, ".resp_state"}, 32'(state_out), 32'h3);
    chk({tag, ".ack"},        32'(ack), exp_id ? 32'h2 : 32'h1);
    chk({tag, ".result"},     32'(result), 32'(exp_res));
    chk({tag, ".err"},        32'(err), 32'(exp_err));
    req = r_after;
    tick();
    chk({tag, ".idle_ack"},    32'(ack), 32'h0);
    chk({tag, ".idle_result"}, 32'(result), 32'(exp_res));
  endtask

  initial begin
    reset_a = 1'b0; req = 2'b00;
    a0 = 8'd0; b0 = 8'd0; a1 = 8'd0; b1 = 8'd0;
    mult_done = 1'b0; mult_product = 16'h0;

    // reset state
    do_reset();
    chk("rst.state",  32'(state_out), 32'h0);
    chk("rst.ack",    32'(ack), 32'h0);
    chk("rst.result", 32'(result), 32'h0);
    chk("rst.err",    32'(err), 32'h0);
    chk("rst.busy",   32'(busy), 32'h0);
    chk("rst.start",  32'(mult_start), 32'h0);
    chk("rst.mult_a", 32'(mult_a), 32'h0);
    chk("rst.grant",  32'(grant_id), 32'h0);

    // spurious done in IDLE
    mult_done = 1'b1; mult_product = 16'h1234;
    tick();
    mult_done = 1'b0; mult_product = 16'h0;
    chk("spur.state", 32'(state_out), 32'h0);
    chk("spur.ack",   32'(ack), 32'h0);
    chk("spur.busy",  32'(busy), 32'h0);
    chk("spur.result", 32'(result), 32'h0);

    // single request: 12*11, done in the 5th WAIT cycle
    a0 = 8'd12; b0 = 8'd11;
    do_txn("single", 2'b01, 4, 1'b1, 16'd132, 1'b0, 8'd12, 8'd11, 16'd132, 1'b0, 2'b00);
    chk("single.busy_after", 32'(busy), 32'h0);

    // contention from a fresh reset: 0, 1, 0, 1
    do_reset();
    a0 = 8'd3; b0 = 8'd4; a1 = 8'd200; b1 = 8'd255;
    do_txn("cont1", 2'b11, 1, 1'b1, 16'd12,    1'b0, 8'd3,   8'd4,   16'd12,    1'b0, 2'b11);
    do_txn("cont2", 2'b11, 0, 1'b1, 16'd51000, 1'b1, 8'd200, 8'd255, 16'd51000, 1'b0, 2'b11);
    do_txn("cont3", 2'b11, 2, 1'b1, 16'd12,    1'b0, 8'd3,   8'd4,   16'd12,    1'b0, 2'b11);
    do_txn("cont4", 2'b11, 0, 1'b1, 16'd51000, 1'b1, 8'd200, 8'd255, 16'd51000, 1'b0, 2'b00);

    // timeout: 16 WAIT cycles, no done (last grant was 1, so 0 wins)
    a0 = 8'd5; b0 = 8'd6;
    do_txn("tmo", 2'b01, 15, 1'b0, 16'h0, 1'b0, 8'd5, 8'd6, 16'h0, 1'b1, 2'b00);
    chk("tmo.busy_after", 32'(busy), 32'h0);
    chk("tmo.err_held",   32'(err), 32'h1);

    // done arrives exactly at timer == TIMEOUT-1
    a1 = 8'd9; b1 = 8'd10;
    do_txn("coll", 2'b10, 15, 1'b1, 16'hBEEF, 1'b1, 8'd9, 8'd10, 16'hBEEF, 1'b0, 2'b00);

    // reset mid-WAIT with requester 1 active
    a1 = 8'd7; b1 = 8'd9;
    req = 2'b10;
    tick();
    tick();
    chk("rstw.in_wait", 32'(state_out), 32'h2);
    tick();
    reset_a = 1'b1;
    tick();
    reset_a = 1'b0;
    chk("rstw.state", 32'(state_out), 32'h0);
    chk("rstw.ack",   32'(ack), 32'h0);
    chk("rstw.start", 32'(mult_start), 32'h0);
    chk("rstw.result", 32'(result), 32'h0);
    chk("rstw.err",   32'(err), 32'h0);
    do_txn("rstw.resume", 2'b10, 1, 1'b1, 16'd63, 1'b1, 8'd7, 8'd9, 16'd63, 1'b0, 2'b00);

    // after reset, a tie goes to requester 0 first
    do_reset();
    a0 = 8'd2; b0 = 8'd8;
    do_txn("rsttie", 2'b11, 0, 1'b1, 16'd16, 1'b0, 8'd2, 8'd8, 16'd16, 1'b0, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
